l1_cache_arbiter: RTL and testbench
===================================

Name: l1_cache_arbiter

Overview:
- Responder (slave) end of the L1IC_ARB and L1DC_ARB cache-line request/acknowledge protocols.
- Arbitrates between the L1 instruction-cache and L1 data-cache miss/writeback requests and forwards one cache-line transaction at a time to system memory as SysMem master.
- Returns the read line, or a write completion, to the requesting cache.
- Sits between the L1 caches and sys_mem_model (or a future L2).

Parameters:
- RR_EN, 1, 1 = round-robin between IC and DC; 0 = fixed priority, DC wins.
- (Widths from cpu_params_pkg: PC_SZ, CL_SZ, CL_LEN. Write-data struct ARB_Data from cpu_structs_pkg, fields rw, rw_addr, wr_data.)

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous, active-high reset
- ic_req_addr  input  PC_SZ-CL_SZ  IC line address
- ic_req_valid  input  1  IC request valid
- ic_req_rdy  output  1  IC request accepted
- ic_ack_data  output  CL_LEN*8  line returned to IC
- ic_ack_valid  output  1  IC acknowledge valid
- ic_ack_rdy  input  1  IC ready for ack
- dc_req_data  input  $bits(ARB_Data)  {rw, rw_addr, wr_data} from DC; rw=1 read
- dc_req_valid  input  1  DC request valid
- dc_req_rdy  output  1  DC request accepted
- dc_ack_data  output  CL_LEN*8  line returned to DC (don't-care for writes)
- dc_ack_valid  output  1  DC acknowledge valid
- dc_ack_rdy  input  1  DC ready for ack
- sm_req_rw, sm_req_addr, sm_req_wr_data, sm_req_valid  output  1/PC_SZ-CL_SZ/CL_LEN*8/1  SysMem request
- sm_req_rdy  input  1  SysMem accepted request
- sm_ack_rd_data  input  CL_LEN*8  SysMem read line
- sm_ack_valid  input  1  SysMem ack valid
- sm_ack_rdy  output  1  arbiter ready for SysMem ack

Behaviour:
- Handshakes: a transfer occurs on any edge where valid & rdy are both 1. Once asserted, a valid is held with its payload stable until that handshake.
- FSM states: IDLE -> SM_REQ -> SM_ACK -> L1_ACK -> IDLE. Only one transaction is in flight.
- IDLE:
  - grant = IC if only ic_req_valid; DC if only dc_req_valid.
  - If both: RR_EN=1 grants the master not served last (last_gnt register); RR_EN=0 grants DC.
  - ic_req_rdy / dc_req_rdy = 1 combinationally only for the granted master while in IDLE; 0 in every other state.
  - On handshake, latch rw (IC is always read), addr, wr_data, and owner. Go to SM_REQ and update last_gnt.
- SM_REQ:
  - sm_req_valid = 1 with latched fields. sm_req_rw = 1 for read, 0 for write.
  - Leave on sm_req_rdy to SM_ACK.
  - sm_req_valid is registered, so it rises 1 cycle after L1 acceptance.
- SM_ACK:
  - sm_ack_rdy = 1.
  - On sm_ack_valid, latch sm_ack_rd_data (reads only; writes keep old data) and go to L1_ACK.
- L1_ACK:
  - Owner's ack_valid = 1; ack_data = latched line. The other master's ack_valid = 0.
  - On owner's ack_rdy, go to IDLE.
  - A new grant can be made on the cycle after, so back-to-back transactions have a 1-cycle IDLE bubble.
- Min latency, L1 accept to L1 ack_valid, with SysMem rdy/valid immediate: 3 cycles.
- A write is acknowledged to DC exactly like a read (ack_valid pulse); ack_data is don't-care.
- Requests that arrive while not IDLE wait; the requester holds valid.
- Reset (any state, including mid-transaction):
  - State = IDLE; last_gnt = DC, so IC wins the first tie when RR_EN=1.
  - All outputs 0: req_rdy, ack_valid, sm_req_*, sm_ack_rdy, ack_data.
  - An in-flight transaction is dropped; SysMem and caches are reset together.
- sm_ack_valid seen outside SM_ACK is ignored (sm_ack_rdy = 0).

Optional Feature:
- Macro: L1_ARB_PERF_CNT_EN.
- Defined: adds outputs ic_gnt_cnt[31:0], dc_gnt_cnt[31:0] and wait_cnt[31:0].
  - ic_gnt_cnt / dc_gnt_cnt increment on each accepted request of that master.
  - wait_cnt increments each cycle in which a master's req_valid=1 and its req_rdy=0.
  - All saturate at 32'hFFFF_FFFF and clear on reset_in.
- Undefined: no counters and no extra ports; functional behaviour is identical.

Test Plan:
- IC read 0x0100_000 alone, SysMem immediate, returns line 128'hA5...A5 -> ic_req_rdy same cycle; sm_req_valid next cycle with rw=1, addr 0x0100_000; ic_ack_valid 3 cycles after accept with data A5..A5; dc_ack_valid stays 0.
- DC write rw=0, addr 0x0200_010, wr_data 128'h1234... -> sm_req_rw=0, sm_req_wr_data=128'h1234...; dc_ack_valid pulses once; sm_ack_rd_data ignored.
- RR_EN=1, IC and DC both valid continuously for 4 transactions -> grant order IC, DC, IC, DC; 1-cycle IDLE between them.
- RR_EN=0, both valid for 3 transactions -> DC, DC, DC while DC valid stays high; IC is granted only after DC drops valid.
- Backpressure: sm_req_rdy low 5 cycles, sm_ack_valid delayed 7 cycles, dc_ack_rdy low 4 cycles -> all payloads stable; no second grant; exactly one L1 ack per request.
- reset_in pulsed 1 cycle in SM_ACK -> next cycle all outputs 0, state IDLE; pending IC+DC requests then grant IC first (RR_EN=1).

Source files
------------

// File: rtl/l1_cache_arbiter.sv
// Purpose: arbitrates L1 IC/DC cache-line requests onto one SysMem master port, one transaction at a time.
// Latency: 3 cycles from L1 request accept to L1 ack_valid when SysMem accepts and answers immediately.
// Backpressure: req_rdy is only offered in IDLE; SysMem and L1 ack stalls hold the FSM with payloads stable.
//
// Ports:
//   clk_in, reset_in                 clock, synchronous active-high reset
//   ic_req_* / ic_ack_*              IC line-read request and line return (IC always reads)
//   dc_req_* / dc_ack_*              DC request {rw, rw_addr, wr_data} (rw=1 read) and line/write-done return
//   sm_req_* / sm_ack_*              SysMem master request and response
//   ic_gnt_cnt, dc_gnt_cnt, wait_cnt saturating performance counters, present only with L1_ARB_PERF_CNT_EN
//
// Parameters: RR_EN=1 alternates IC/DC on a tie, RR_EN=0 gives DC fixed priority.
// Macro L1_ARB_PERF_CNT_EN adds the performance counters; undefined leaves the port list without them.
module l1_cache_arbiter #(
  parameter int RR_EN  = 1,
  parameter int PC_SZ  = 32,
  parameter int CL_SZ  = 4,
  parameter int CL_LEN = 16
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [PC_SZ-CL_SZ-1:0]              ic_req_addr,
  input  logic                                ic_req_valid,
  output logic                                ic_req_rdy,
  output logic [CL_LEN*8-1:0]                 ic_ack_data,
  output logic                                ic_ack_valid,
  input  logic                                ic_ack_rdy,
  input  logic [1+(PC_SZ-CL_SZ)+CL_LEN*8-1:0] dc_req_data,
  input  logic                                dc_req_valid,
  output logic                                dc_req_rdy,
  output logic [CL_LEN*8-1:0]                 dc_ack_data,
  output logic                                dc_ack_valid,
  input  logic                                dc_ack_rdy,
  output logic                                sm_req_rw,
  output logic [PC_SZ-CL_SZ-1:0]              sm_req_addr,
  output logic [CL_LEN*8-1:0]                 sm_req_wr_data,
  output logic                                sm_req_valid,
  input  logic                                sm_req_rdy,
  input  logic [CL_LEN*8-1:0]                 sm_ack_rd_data,
  input  logic                                sm_ack_valid,
`ifdef L1_ARB_PERF_CNT_EN
  output logic [31:0]                         ic_gnt_cnt,
  output logic [31:0]                         dc_gnt_cnt,
  output logic [31:0]                         wait_cnt,
`endif
  output logic                                sm_ack_rdy
);

  localparam int AW = PC_SZ - CL_SZ;
  localparam int DW = CL_LEN * 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SM_REQ = 2'd1,
    ST_SM_ACK = 2'd2,
    ST_L1_ACK = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_last_gnt_dc;   // 1 = DC was served last
  logic            r_owner_dc;      // master that owns the in-flight transaction
  logic            r_rw;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wr_data;
  logic [DW-1:0]   r_line;
  logic            r_sm_req_valid;
  logic            r_sm_ack_rdy;
  logic            r_ic_ack_valid;
  logic            r_dc_ack_valid;

  logic            w_dc_rw;
  logic [AW-1:0]   w_dc_addr;
  logic [DW-1:0]   w_dc_wr_data;
  logic            w_gnt_dc;
  logic            w_idle;
  logic            w_ic_hs;
  logic            w_dc_hs;

  assign w_dc_rw      = dc_req_data[AW+DW];
  assign w_dc_addr    = dc_req_data[DW +: AW];
  assign w_dc_wr_data = dc_req_data[DW-1:0];

  // On a tie, round-robin picks whoever was not served last; otherwise DC wins.
  always_comb begin
    w_gnt_dc = 1'b0;
    if (dc_req_valid && !ic_req_valid) begin
      w_gnt_dc = 1'b1;
    end else if (dc_req_valid && ic_req_valid) begin
      w_gnt_dc = (RR_EN != 0) ? !r_last_gnt_dc : 1'b1;
    end
  end

  // No request is accepted during the reset cycle itself.
  assign w_idle     = (r_state == ST_IDLE) && !reset_in;
  assign ic_req_rdy = w_idle && ic_req_valid && !w_gnt_dc;
  assign dc_req_rdy = w_idle && dc_req_valid &&  w_gnt_dc;
  assign w_ic_hs    = ic_req_valid && ic_req_rdy;
  assign w_dc_hs    = dc_req_valid && dc_req_rdy;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state        <= ST_IDLE;
      r_last_gnt_dc  <= 1'b1;
      r_owner_dc     <= 1'b0;
      r_rw           <= 1'b0;
      r_addr         <= '0;
      r_wr_data      <= '0;
      r_line         <= '0;
      r_sm_req_valid <= 1'b0;
      r_sm_ack_rdy   <= 1'b0;
      r_ic_ack_valid <= 1'b0;
      r_dc_ack_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ic_hs) begin
            r_rw           <= 1'b1;
            r_addr         <= ic_req_addr;
            r_wr_data      <= '0;
            r_owner_dc     <= 1'b0;
            r_last_gnt_dc  <= 1'b0;
            r_sm_req_valid <= 1'b1;
            r_state        <= ST_SM_REQ;
          end else if (w_dc_hs) begin
            r_rw           <= w_dc_rw;
            r_addr         <= w_dc_addr;
            r_wr_data      <= w_dc_wr_data;
            r_owner_dc     <= 1'b1;
            r_last_gnt_dc  <= 1'b1;
            r_sm_req_valid <= 1'b1;
            r_state        <= ST_SM_REQ;
          end
        end
        ST_SM_REQ: begin
          if (sm_req_rdy) begin
            r_sm_req_valid <= 1'b0;
            r_sm_ack_rdy   <= 1'b1;
            r_state        <= ST_SM_ACK;
          end
        end
        ST_SM_ACK: begin
          if (sm_ack_valid) begin
            // Write completions carry no line; keep the previous one.
            if (r_rw) begin
              r_line <= sm_ack_rd_data;
            end
            r_sm_ack_rdy   <= 1'b0;
            r_ic_ack_valid <= !r_owner_dc;
            r_dc_ack_valid <=  r_owner_dc;
            r_state        <= ST_L1_ACK;
          end
        end
        ST_L1_ACK: begin
          if (r_owner_dc ? dc_ack_rdy : ic_ack_rdy) begin
            r_ic_ack_valid <= 1'b0;
            r_dc_ack_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sm_req_rw      = r_rw;
  assign sm_req_addr    = r_addr;
  assign sm_req_wr_data = r_wr_data;
  assign sm_req_valid   = r_sm_req_valid;
  assign sm_ack_rdy     = r_sm_ack_rdy;
  assign ic_ack_valid   = r_ic_ack_valid;
  assign dc_ack_valid   = r_dc_ack_valid;
  assign ic_ack_data    = r_line;
  assign dc_ack_data    = r_line;

`ifdef L1_ARB_PERF_CNT_EN
  logic [31:0] r_ic_gnt_cnt;
  logic [31:0] r_dc_gnt_cnt;
  logic [31:0] r_wait_cnt;
  logic        w_waiting;

  // One wait tick per cycle in which any master is stalled.
  assign w_waiting = (ic_req_valid && !ic_req_rdy) || (dc_req_valid && !dc_req_rdy);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ic_gnt_cnt <= '0;
      r_dc_gnt_cnt <= '0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_ic_hs && (r_ic_gnt_cnt != 32'hFFFF_FFFF)) begin
        r_ic_gnt_cnt <= r_ic_gnt_cnt + 32'd1;
      end
      if (w_dc_hs && (r_dc_gnt_cnt != 32'hFFFF_FFFF)) begin
        r_dc_gnt_cnt <= r_dc_gnt_cnt + 32'd1;
      end
      if (w_waiting && (r_wait_cnt != 32'hFFFF_FFFF)) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
    end
  end

  assign ic_gnt_cnt = r_ic_gnt_cnt;
  assign dc_gnt_cnt = r_dc_gnt_cnt;
  assign wait_cnt   = r_wait_cnt;
`else
  // Performance counters compiled out; no extra state or ports.
`endif

endmodule

// File: tb/tb_l1_cache_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 is fixed DC priority.
// A small SysMem responder answers each request after ack_wait cycles with mem_line.
// Inputs change 2ns after the rising edge; outputs are sampled there or 1ns later.
module tb_l1_cache_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int RW = 1 + AW + DW;

  localparam logic [AW-1:0] IC_A  = 28'h0100000;
  localparam logic [AW-1:0] DC_W  = 28'h0200010;
  localparam logic [AW-1:0] ICA   = 28'h0000100;
  localparam logic [AW-1:0] DCA   = 28'h0000200;
  localparam logic [AW-1:0] DCB   = 28'h0300000;
  localparam logic [DW-1:0] L_A5  = {16{8'hA5}};
  localparam logic [DW-1:0] L_C3  = {16{8'hC3}};
  localparam logic [DW-1:0] WD    = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  logic          clk;
  logic          rst;

  logic [AW-1:0] ic_req_addr    [2];
  logic          ic_req_valid   [2];
  logic          ic_req_rdy     [2];
  logic [DW-1:0] ic_ack_data    [2];
  logic          ic_ack_valid   [2];
  logic          ic_ack_rdy     [2];
  logic [RW-1:0] dc_req_data    [2];
  logic          dc_req_valid   [2];
  logic          dc_req_rdy     [2];
  logic [DW-1:0] dc_ack_data    [2];
  logic          dc_ack_valid   [2];
  logic          dc_ack_rdy     [2];
  logic          sm_req_rw      [2];
  logic [AW-1:0] sm_req_addr    [2];
  logic [DW-1:0] sm_req_wr_data [2];
  logic          sm_req_valid   [2];
  logic          sm_req_rdy     [2];
  logic [DW-1:0] sm_ack_rd_data [2];
  logic          sm_ack_valid   [2];
  logic          sm_ack_rdy     [2];

  int            ack_wait [2];
  logic [DW-1:0] mem_line [2];
  logic          m_pend   [2];
  int            m_cnt    [2];
  logic          hs_req   [2];
  logic          hs_ack   [2];
  logic          m_rst;

  int            n_vec;
  int            n_err;
  logic          exp_ic;
  logic          bad;
  int            ncyc;

  l1_cache_arbiter #(.RR_EN(1)) u_rr (
    .clk_in(clk), .reset_in(rst),
    .ic_req_addr(ic_req_addr[0]), .ic_req_valid(ic_req_valid[0]), .ic_req_rdy(ic_req_rdy[0]),
    .ic_ack_data(ic_ack_data[0]), .ic_ack_valid(ic_ack_valid[0]), .ic_ack_rdy(ic_ack_rdy[0]),
    .dc_req_data(dc_req_data[0]), .dc_req_valid(dc_req_valid[0]), .dc_req_rdy(dc_req_rdy[0]),
    .dc_ack_data(dc_ack_data[0]), .dc_ack_valid(dc_ack_valid[0]), .dc_ack_rdy(dc_ack_rdy[0]),
    .sm_req_rw(sm_req_rw[0]), .sm_req_addr(sm_req_addr[0]), .sm_req_wr_data(sm_req_wr_data[0]),
    .sm_req_valid(sm_req_valid[0]), .sm_req_rdy(sm_req_rdy[0]),
    .sm_ack_rd_data(sm_ack_rd_data[0]), .sm_ack_valid(sm_ack_valid[0]), .sm_ack_rdy(sm_ack_rdy[0])
  );

  l1_cache_arbiter #(.RR_EN(0)) u_fp (
    .clk_in(clk), .reset_in(rst),
    .ic_req_addr(ic_req_addr[1]), .ic_req_valid(ic_req_valid[1]), .ic_req_rdy(ic_req_rdy[1]),
    .ic_ack_data(ic_ack_data[1]), .ic_ack_valid(ic_ack_valid[1]), .ic_ack_rdy(ic_ack_rdy[1]),
    .dc_req_data(dc_req_data[1]), .dc_req_valid(dc_req_valid[1]), .dc_req_rdy(dc_req_rdy[1]),
    .dc_ack_data(dc_ack_data[1]), .dc_ack_valid(dc_ack_valid[1]), .dc_ack_rdy(dc_ack_rdy[1]),
    .sm_req_rw(sm_req_rw[1]), .sm_req_addr(sm_req_addr[1]), .sm_req_wr_data(sm_req_wr_data[1]),
    .sm_req_valid(sm_req_valid[1]), .sm_req_rdy(sm_req_rdy[1]),
    .sm_ack_rd_data(sm_ack_rd_data[1]), .sm_ack_valid(sm_ack_valid[1]), .sm_ack_rdy(sm_ack_rdy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SysMem responder: handshakes are observed mid-cycle, responses driven 1ns after the edge.
  always begin
    @(negedge clk);
    m_rst = rst;
    for (int k = 0; k < 2; k++) begin
      hs_req[k] = sm_req_valid[k] & sm_req_rdy[k];
      hs_ack[k] = sm_ack_valid[k] & sm_ack_rdy[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (m_rst) begin
        m_pend[k]       = 1'b0;
        sm_ack_valid[k] = 1'b0;
      end else begin
        if (hs_ack[k]) sm_ack_valid[k] = 1'b0;
        if (hs_req[k]) begin
          m_pend[k] = 1'b1;
          m_cnt[k]  = ack_wait[k];
        end
        if (m_pend[k]) begin
          if (m_cnt[k] == 0) begin
            sm_ack_valid[k]   = 1'b1;
            sm_ack_rd_data[k] = mem_line[k];
            m_pend[k]         = 1'b0;
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ic_req_addr[k]  = '0;
      ic_req_valid[k] = 1'b0;
      ic_ack_rdy[k]   = 1'b1;
      dc_req_data[k]  = '0;
      dc_req_valid[k] = 1'b0;
      dc_ack_rdy[k]   = 1'b1;
      sm_req_rdy[k]   = 1'b1;
      ack_wait[k]     = 0;
      mem_line[k]     = L_A5;
    end
    tick();
    tick();
    // Reset state, both instances.
    for (int k = 0; k < 2; k++) begin
      chk("rst_sm_req_valid", sm_req_valid[k], 0);
      chk("rst_sm_ack_rdy",   sm_ack_rdy[k],   0);
      chk("rst_ic_ack_valid", ic_ack_valid[k], 0);
      chk("rst_dc_ack_valid", dc_ack_valid[k], 0);
    end
    rst = 1'b0;
    tick();

    // IC read alone, SysMem immediate.
    ic_req_addr[0]  = IC_A;
    ic_req_valid[0] = 1'b1;
    #1;
    chk("t1_ic_rdy", ic_req_rdy[0], 1);
    chk("t1_dc_rdy", dc_req_rdy[0], 0);
    tick();
    chk("t1_ic_rdy_busy", ic_req_rdy[0], 0);
    ic_req_valid[0] = 1'b0;
    chk("t1_sm_valid", sm_req_valid[0], 1);
    chk("t1_sm_rw",    sm_req_rw[0],    1);
    chk("t1_sm_addr",  sm_req_addr[0],  IC_A);
    tick();
    chk("t1_sm_ack_rdy",  sm_ack_rdy[0],   1);
    chk("t1_sm_valid_lo", sm_req_valid[0], 0);
    chk("t1_ack_early",   ic_ack_valid[0], 0);
    tick();
    chk("t1_ic_ack",      ic_ack_valid[0], 1);
    chk("t1_ic_data",     ic_ack_data[0],  L_A5);
    chk("t1_dc_ack",      dc_ack_valid[0], 0);
    tick();
    chk("t1_ic_ack_drop", ic_ack_valid[0], 0);

    // DC write; the SysMem line returned must be ignored.
    mem_line[0]     = '1;
    dc_req_data[0]  = {1'b0, DC_W, WD};
    dc_req_valid[0] = 1'b1;
    #1;
    chk("t2_dc_rdy", dc_req_rdy[0], 1);
    tick();
    dc_req_valid[0] = 1'b0;
    chk("t2_sm_rw",   sm_req_rw[0],      0);
    chk("t2_sm_addr", sm_req_addr[0],    DC_W);
    chk("t2_sm_wd",   sm_req_wr_data[0], WD);
    tick();
    tick();
    chk("t2_dc_ack",      dc_ack_valid[0], 1);
    chk("t2_ic_ack",      ic_ack_valid[0], 0);
    chk("t2_line_kept",   dc_ack_data[0],  L_A5);
    tick();
    chk("t2_dc_ack_drop", dc_ack_valid[0], 0);

    // Round-robin with both masters always valid: IC, DC, IC, DC.
    ic_req_addr[0]  = ICA;
    ic_req_valid[0] = 1'b1;
    dc_req_data[0]  = {1'b1, DCA, {DW{1'b0}}};
    dc_req_valid[0] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_ic = (t % 2 == 0);
      #1;
      chk("t3_ic_rdy", ic_req_rdy[0], exp_ic);
      chk("t3_dc_rdy", dc_req_rdy[0], !exp_ic);
      tick();
      chk("t3_addr", sm_req_addr[0], exp_ic ? ICA : DCA);
      tick();
      tick();
      chk("t3_own_ack",   exp_ic ? ic_ack_valid[0] : dc_ack_valid[0], 1);
      chk("t3_other_ack", exp_ic ? dc_ack_valid[0] : ic_ack_valid[0], 0);
      tick();
      chk("t3_bubble", sm_req_valid[0], 0);
    end
    ic_req_valid[0] = 1'b0;
    dc_req_valid[0] = 1'b0;

    // Fixed priority: DC wins every tie; IC only after DC drops valid.
    ic_req_addr[1]  = ICA;
    ic_req_valid[1] = 1'b1;
    dc_req_data[1]  = {1'b1, DCA, {DW{1'b0}}};
    dc_req_valid[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("t4_dc_rdy", dc_req_rdy[1], 1);
      chk("t4_ic_rdy", ic_req_rdy[1], 0);
      tick();
      chk("t4_addr", sm_req_addr[1], DCA);
      tick();
      tick();
      chk("t4_dc_ack", dc_ack_valid[1], 1);
      tick();
    end
    dc_req_valid[1] = 1'b0;
    #1;
    chk("t4_ic_rdy_late", ic_req_rdy[1], 1);
    tick();
    ic_req_valid[1] = 1'b0;
    chk("t4_ic_addr", sm_req_addr[1], ICA);
    tick();
    tick();
    chk("t4_ic_ack", ic_ack_valid[1], 1);
    tick();

    // Backpressure on every leg, IC waiting the whole time.
    mem_line[0]     = L_C3;
    ack_wait[0]     = 7;
    sm_req_rdy[0]   = 1'b0;
    dc_ack_rdy[0]   = 1'b0;
    dc_req_data[0]  = {1'b1, DCB, {DW{1'b0}}};
    dc_req_valid[0] = 1'b1;
    #1;
    chk("t5_dc_rdy", dc_req_rdy[0], 1);
    tick();
    dc_req_valid[0] = 1'b0;
    ic_req_addr[0]  = ICA;
    ic_req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_sm_valid_hold", sm_req_valid[0], 1);
      chk("t5_sm_addr_hold",  sm_req_addr[0],  DCB);
      chk("t5_no_grant",      ic_req_rdy[0],   0);
      tick();
    end
    sm_req_rdy[0] = 1'b1;
    tick();
    chk("t5_sm_ack_rdy", sm_ack_rdy[0], 1);
    bad  = 1'b0;
    ncyc = 0;
    while (!dc_ack_valid[0] && ncyc < 30) begin
      if (ic_req_rdy[0] !== 1'b0 || sm_req_valid[0] !== 1'b0) bad = 1'b1;
      tick();
      ncyc++;
    end
    // 7 cycles of SysMem delay plus the SM_ACK->L1_ACK register stage.
    chk("t5_ack_wait_cycles", ncyc, 8);
    chk("t5_quiet_while_wait", bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_ack_hold",  dc_ack_valid[0], 1);
      chk("t5_data_hold", dc_ack_data[0],  L_C3);
      chk("t5_no_grant2", ic_req_rdy[0],   0);
      tick();
    end
    dc_ack_rdy[0] = 1'b1;
    ack_wait[0]   = 0;
    tick();
    chk("t5_single_ack", dc_ack_valid[0], 0);
    #1;
    chk("t5_ic_next", ic_req_rdy[0], 1);
    tick();
    chk("t5_ic_addr", sm_req_addr[0], ICA);
    tick();
    tick();
    chk("t5_ic_ack", ic_ack_valid[0], 1);
    chk("t5_dc_no_second_ack", dc_ack_valid[0], 0);
    tick();
    ic_req_valid[0] = 1'b0;

    // Reset in SM_ACK with both masters pending.
    ack_wait[0]     = 3;
    ic_req_addr[0]  = ICA;
    ic_req_valid[0] = 1'b1;
    dc_req_data[0]  = {1'b1, DCA, {DW{1'b0}}};
    dc_req_valid[0] = 1'b1;
    #1;
    chk("t6_dc_wins_after_ic", dc_req_rdy[0], 1);
    tick();
    tick();
    chk("t6_in_sm_ack", sm_ack_rdy[0], 1);
    rst = 1'b1;
    #1;
    chk("t6_ic_rdy_in_rst", ic_req_rdy[0], 0);
    chk("t6_dc_rdy_in_rst", dc_req_rdy[0], 0);
    tick();
    chk("t6_sm_ack_rdy", sm_ack_rdy[0],     0);
    chk("t6_sm_valid",   sm_req_valid[0],   0);
    chk("t6_sm_rw",      sm_req_rw[0],      0);
    chk("t6_sm_addr",    sm_req_addr[0],    0);
    chk("t6_sm_wd",      sm_req_wr_data[0], 0);
    chk("t6_ic_ack",     ic_ack_valid[0],   0);
    chk("t6_dc_ack",     dc_ack_valid[0],   0);
    chk("t6_ic_data",    ic_ack_data[0],    0);
    chk("t6_dc_data",    dc_ack_data[0],    0);
    chk("t6_fp_data",    dc_ack_data[1],    0);
    rst         = 1'b0;
    ack_wait[0] = 0;
    #1;
    chk("t6_ic_first", ic_req_rdy[0], 1);
    chk("t6_dc_wait",  dc_req_rdy[0], 0);
    tick();
    chk("t6_ic_addr", sm_req_addr[0], ICA);
    chk("t6_ic_rw",   sm_req_rw[0],   1);
    ic_req_valid[0] = 1'b0;
    dc_req_valid[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
